// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame transmitter and its matching receiver:
// state encoding, line levels and a counter-width helper.
package serial_frame_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    // A counter for n states needs at least one bit, even when n is 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_frame_tx_baud_tick_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while a frame runs and flags the
// first and last cycle of every bit period.
module baud_tick_gen
    import serial_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic tick_first,
    output logic tick_last
);

    localparam int CNT_W = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clear || !run || (cnt_reg == CNT_LAST)) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // With CLKS_PER_BIT=1 both ticks are high on every running cycle.
    assign tick_first = run && (cnt_reg == '0);
    assign tick_last  = run && (cnt_reg == CNT_LAST);

endmodule

// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: start bit, WIDTH data bits LSB first, optional
// parity, STOP_BITS stop bits, each bit held for CLKS_PER_BIT clocks.
module serial_frame_tx
    import serial_frame_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_line,
    output logic             busy,
    output logic             bit_strobe
);

    localparam int IDX_W = $clog2(WIDTH + 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    logic [2:0]       state_reg, state_next;
    logic [WIDTH-1:0] shreg_reg, shreg_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             parity_reg;
    logic             tx_line_reg, line_next;
    logic             accept;
    logic             tick_first, tick_last;

    assign accept = tx_valid && tx_ready;

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (accept),
        .run        (busy),
        .tick_first (tick_first),
        .tick_last  (tick_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:   if (accept) state_next = START;
            START:  if (tick_last) state_next = DATA;
            DATA:   if (tick_last && (idx_reg == DATA_LAST))
                        state_next = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY: if (tick_last) state_next = STOP;
            STOP:   if (tick_last && (idx_reg == STOP_LAST)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The line level is chosen from the upcoming state so tx_line can be a flop.
    always_comb begin
        tx_ready  = (state_reg == IDLE);
        busy      = (state_reg != IDLE);
        line_next = LINE_IDLE;
        case (state_next)
            IDLE:    line_next = LINE_IDLE;
            START:   line_next = LINE_START;
            DATA:    line_next = shreg_next[0];
            PARITY:  line_next = parity_reg;
            STOP:    line_next = LINE_STOP;
            default: line_next = LINE_IDLE;
        endcase
    end

    // idx counts data bits in DATA and stop bits in STOP; it restarts on every state change.
    always_comb begin
        shreg_next = shreg_reg;
        idx_next   = idx_reg;
        if (accept) begin
            shreg_next = tx_data;
            idx_next   = '0;
        end else if (tick_last) begin
            if (state_reg == DATA) begin
                shreg_next = shreg_reg >> 1;
            end
            if (state_next != state_reg) begin
                idx_next = '0;
            end else begin
                idx_next = idx_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_reg   <= '0;
            idx_reg     <= '0;
            parity_reg  <= 1'b0;
            tx_line_reg <= LINE_IDLE;
        end else begin
            shreg_reg   <= shreg_next;
            idx_reg     <= idx_next;
            tx_line_reg <= line_next;
            if (accept) begin
                parity_reg <= (^tx_data) ^ (PARITY_ODD != 0);
            end
        end
    end

    assign tx_line    = tx_line_reg;
    assign bit_strobe = tick_first;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: four configurations share one clock and
// reset; frames are checked bit by bit against hand-written line sequences.
module tb_serial_frame_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data;
    logic [3:0] valid;
    logic [3:0] ready_o, line_o, busy_o, strobe_o;

    int checks;
    int errors;

    // 0: plain 8N1, 1: even parity, 2: odd parity, 3: CLKS_PER_BIT=1 with 2 stop bits
    serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(valid[0]),
        .tx_ready(ready_o[0]), .tx_line(line_o[0]), .busy(busy_o[0]), .bit_strobe(strobe_o[0]));
    serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(valid[1]),
        .tx_ready(ready_o[1]), .tx_line(line_o[1]), .busy(busy_o[1]), .bit_strobe(strobe_o[1]));
    serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(valid[2]),
        .tx_ready(ready_o[2]), .tx_line(line_o[2]), .busy(busy_o[2]), .bit_strobe(strobe_o[2]));
    serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(valid[3]),
        .tx_ready(ready_o[3]), .tx_line(line_o[3]), .busy(busy_o[3]), .bit_strobe(strobe_o[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // exp lists line levels in time order, first bit in the leftmost used position.
    typedef struct {
        int          sel;
        logic [7:0]  data;
        int          nbits;
        int          cpb;
        logic [15:0] exp;
    } frame_vec_t;

    frame_vec_t vecs[5];

    task automatic chk(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %b want %b at %0t", name, act, req, $time);
        end
    endtask

    task automatic chk_idle_now(input int sel, input string tag);
        chk($sformatf("%s sel%0d idle line", tag, sel), line_o[sel], 1'b1);
        chk($sformatf("%s sel%0d idle ready", tag, sel), ready_o[sel], 1'b1);
        chk($sformatf("%s sel%0d idle busy", tag, sel), busy_o[sel], 1'b0);
        chk($sformatf("%s sel%0d idle strobe", tag, sel), strobe_o[sel], 1'b0);
    endtask

    // Caller raises valid at a negedge; the first negedge here is the first start cycle.
    task automatic check_bits(input int sel, input logic [15:0] exp, input int nbits, input int cpb,
                              input bit drop, input bit mid_en, input logic [7:0] mid_data);
        for (int i = 0; i < nbits; i++) begin
            for (int c = 0; c < cpb; c++) begin
                @(negedge clk);
                if (i == 0 && c == 0 && drop) valid[sel] = 1'b0;
                if (mid_en && i == 2 && c == 0) tx_data = mid_data;
                chk($sformatf("sel%0d bit%0d cyc%0d line", sel, i, c), line_o[sel], exp[nbits-1-i]);
                chk($sformatf("sel%0d bit%0d cyc%0d strobe", sel, i, c), strobe_o[sel], c == 0);
                chk($sformatf("sel%0d bit%0d cyc%0d busy", sel, i, c), busy_o[sel], 1'b1);
                chk($sformatf("sel%0d bit%0d cyc%0d ready", sel, i, c), ready_o[sel], 1'b0);
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        valid   = 4'b0000;
        tx_data = 8'h00;

        vecs[0] = '{sel: 0, data: 8'hA5, nbits: 10, cpb: 4, exp: 16'b0_10100101_1};
        vecs[1] = '{sel: 1, data: 8'hA5, nbits: 11, cpb: 4, exp: 16'b0_10100101_0_1};
        vecs[2] = '{sel: 2, data: 8'hA5, nbits: 11, cpb: 4, exp: 16'b0_10100101_1_1};
        vecs[3] = '{sel: 1, data: 8'h01, nbits: 11, cpb: 4, exp: 16'b0_10000000_1_1};
        vecs[4] = '{sel: 3, data: 8'h80, nbits: 11, cpb: 1, exp: 16'b0_00000001_1_1};

        repeat (3) begin
            @(negedge clk);
            for (int s = 0; s < 4; s++) chk_idle_now(s, "reset");
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            for (int s = 0; s < 4; s++) chk_idle_now(s, "post-reset");
        end

        for (int v = 0; v < 5; v++) begin
            tx_data = vecs[v].data;
            valid[vecs[v].sel] = 1'b1;
            check_bits(vecs[v].sel, vecs[v].exp, vecs[v].nbits, vecs[v].cpb, 1'b1, 1'b0, 8'h00);
            @(negedge clk);
            chk_idle_now(vecs[v].sel, $sformatf("vec%0d end", v));
            $display("vec %0d sel %0d data %h done, errors so far %0d", v, vecs[v].sel, vecs[v].data, errors);
        end

        // Back-to-back with valid held; data changes mid-frame must not leak into frame 1.
        tx_data  = 8'h3C;
        valid[0] = 1'b1;
        check_bits(0, 16'b0_00111100_1, 10, 4, 1'b0, 1'b1, 8'hC3);
        @(negedge clk);
        chk_idle_now(0, "b2b gap");
        check_bits(0, 16'b0_11000011_1, 10, 4, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        chk_idle_now(0, "b2b end");
        $display("back-to-back 3C/C3 done, errors so far %0d", errors);

        // Reset during data bit 3 of 8'h00 (frame cycle 17).
        tx_data  = 8'h00;
        valid[0] = 1'b1;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            if (k == 0) valid[0] = 1'b0;
        end
        chk("midrst before line", line_o[0], 1'b0);
        chk("midrst before busy", busy_o[0], 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk_idle_now(0, "midrst async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle_now(0, "midrst release");
        tx_data  = 8'hFF;
        valid[0] = 1'b1;
        check_bits(0, 16'b0_11111111_1, 10, 4, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        chk_idle_now(0, "FF end");
        $display("mid-frame reset then FF done, errors so far %0d", errors);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Framed serial transmitter: accepts a parallel word over a valid/ready handshake and shifts it out on one line, one bit per CLKS_PER_BIT clocks.
- Frame order: start bit, data LSB first, optional parity bit, stop bit(s).
- Drives the serial end of the bit-capture path, so a D-flip-flop-based receiver can sample the line once per bit period.

Parameters:
- WIDTH, 8: data bits per frame (1..16).
- CLKS_PER_BIT, 4: clock cycles each bit is held on tx_line (>=1).
- PARITY_EN, 0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- tx_data  in  WIDTH  word to transmit; sampled only on handshake.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  block can accept a word this cycle.
- tx_line  out  1  serial output; idles high.
- busy  out  1  a frame is in progress.
- bit_strobe  out  1  one-cycle pulse on the first cycle of each bit period, including start, parity and stop.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, tx_line=1, busy=0, bit_strobe=0, tx_ready=1, all counters 0.
  - Reset mid-frame abandons the frame immediately; the line returns high with no glitch low.
- States: IDLE, START, DATA, PARITY, STOP.
  - tx_ready = (state==IDLE), decoded from the registered state.
  - busy = (state!=IDLE).
- Handshake: a word is accepted on a rising edge with tx_valid=1 and tx_ready=1.
  - tx_data is copied into the shift register on that edge; later changes to tx_data do not affect the frame.
  - tx_valid with tx_ready=0 is ignored. The source holds the word until accepted.
- Latency: on the edge after acceptance, state=START, tx_line=0, bit_strobe=1.
- Bit timing: a bit counter runs 0..CLKS_PER_BIT-1. Each state advances when the counter reaches CLKS_PER_BIT-1.
  - START: 1 bit of 0.
  - DATA: WIDTH bits, shift register LSB first; a bit index runs 0..WIDTH-1.
  - PARITY (PARITY_EN=1 only): the XOR of the accepted word, inverted when PARITY_ODD=1.
  - STOP: STOP_BITS bits of 1.
  - After the last stop cycle the state returns to IDLE.
- Frame length in cycles = (1 + WIDTH + PARITY_EN + STOP_BITS) * CLKS_PER_BIT.
- Back-to-back frames: IDLE lasts at least 1 cycle. With tx_valid held high, the next start bit begins exactly 1 cycle after the stop period ends.
- CLKS_PER_BIT=1: bit_strobe is high on every busy cycle; every state lasts exactly one cycle per bit.
- tx_line is registered with no combinational path from inputs.

Decomposition:
- Shared package (serial_frame_pkg) holds:
  - state encoding: IDLE/START/DATA/PARITY/STOP localparams, 3 bits;
  - line level constants: LINE_IDLE=1, LINE_START=0, LINE_STOP=1.
  - The matching receiver uses the same package.
- One sub-module: baud_tick_gen.
  - Counter of width clog2(CLKS_PER_BIT), cleared on frame start.
  - Outputs tick_first (drives bit_strobe) and tick_last (advances the FSM).

Test Plan (WIDTH=8, CLKS_PER_BIT=4 unless noted):
- Reset values: hold rst_n=0 for 3 cycles, then release -> tx_line=1, tx_ready=1, busy=0, bit_strobe=0 throughout and after.
- Single frame: tx_data=8'hA5, tx_valid pulsed for 1 cycle, no parity -> from the next edge tx_line = 0, 1,0,1,0,0,1,0,1, 1.
  - Each bit lasts 4 cycles; 40 cycles total.
  - bit_strobe fires 10 times; tx_ready returns 1 after cycle 40.
- Parity: PARITY_EN=1, tx_data=8'hA5 -> parity bit 0 with PARITY_ODD=0 and 1 with PARITY_ODD=1; frame is 44 cycles.
  - tx_data=8'h01 with even parity gives parity bit 1.
- Back-to-back: tx_valid held high with 8'h3C then 8'hC3 -> exactly 1 idle-high cycle between the end of the first stop bit and the second start bit.
  - Changing tx_data during frame 1 does not alter frame 1 bits.
- Reset mid-frame: assert rst_n=0 during data bit 3 of 8'h00 -> tx_line=1 in the same cycle, without waiting for a clock edge; busy=0.
  - After release, 8'hFF transmits correctly.
- Edge configuration: CLKS_PER_BIT=1, STOP_BITS=2, tx_data=8'h80 -> tx_line = 0,0,0,0,0,0,0,0,1,1,1 (11 cycles); bit_strobe high on all 11.
